// File: rtl/ram_stream_writer.sv
// Valid/ready stream to block-RAM write controller: one word per cycle, sticky frame interrupt and overflow.
// Optional ping-pong banking is enabled with `define RAM_WRITE_CTRL_PINGPONG_EN (adds the intr_bank port).
module ram_stream_writer #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DEPTH     = 9,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       ADDR_STEP = 4
) (
  input  logic                  clk,
  input  logic                  rst_p,
  input  logic                  en,
  input  logic [DATA_W-1:0]     s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  intr_clr,
  output logic                  intr,
  output logic                  ovf,
`ifdef RAM_WRITE_CTRL_PINGPONG_EN
  output logic                  intr_bank,
`endif
  output logic                  busy,
  output logic                  ram_clk,
  output logic                  ram_rst_p,
  output logic                  ram_en,
  output logic [DATA_W/8-1:0]   ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wr
);

  localparam int unsigned       CNT_W    = $clog2(DEPTH + 1);
  localparam int unsigned       WE_W     = DATA_W / 8;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] STEP_A   = ADDR_W'(ADDR_STEP);
`ifdef RAM_WRITE_CTRL_PINGPONG_EN
  localparam logic [ADDR_W-1:0] BANK1_BASE = BASE_ADDR + ADDR_W'(DEPTH * ADDR_STEP);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                ram_en_q, ram_en_d;
  logic [WE_W-1:0]     ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wr_q, ram_wr_d;
  logic                intr_q, intr_d;
  logic                ovf_q, ovf_d;
  logic                busy_q, busy_d;
  logic                beat;
  logic                last;
`ifdef RAM_WRITE_CTRL_PINGPONG_EN
  logic                bank_q, bank_d;
  logic                intr_bank_q, intr_bank_d;
`endif

  assign s_ready   = (state_q == RUN);
  assign beat      = s_valid && s_ready;
  assign last      = beat && (cnt_q == LAST_CNT);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    ram_en_d   = 1'b0;
    ram_we_d   = '0;
    ram_addr_d = ram_addr_q;
    ram_wr_d   = ram_wr_q;
    intr_d     = intr_q;
    ovf_d      = ovf_q;
`ifdef RAM_WRITE_CTRL_PINGPONG_EN
    bank_d      = bank_q;
    intr_bank_d = intr_bank_q;
`endif

    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = en ? RUN : IDLE;
      default: state_d = IDLE;
    endcase

    // ptr_q always holds the byte address the next accepted beat will be written to.
    if (beat) begin
      ram_en_d   = 1'b1;
      ram_we_d   = '1;
      ram_addr_d = ptr_q;
      ram_wr_d   = s_data;
      cnt_d      = cnt_q + CNT_W'(1);
      ptr_d      = ptr_q + STEP_A;
    end

    if (last) begin
      cnt_d = '0;
`ifdef RAM_WRITE_CTRL_PINGPONG_EN
      bank_d      = ~bank_q;
      intr_bank_d = bank_q;
      ptr_d       = bank_q ? BASE_ADDR : BANK1_BASE;
`else
      ptr_d = BASE_ADDR;
`endif
    end

    // A completion in the same cycle as intr_clr wins: intr stays set, ovf is left alone.
    if (last) begin
      intr_d = 1'b1;
      if (intr_q && !intr_clr) ovf_d = 1'b1;
    end else if (intr_clr) begin
      intr_d = 1'b0;
      ovf_d  = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ptr_q      <= BASE_ADDR;
      ram_en_q   <= 1'b0;
      ram_we_q   <= '0;
      ram_addr_q <= BASE_ADDR;
      ram_wr_q   <= '0;
      intr_q     <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
`ifdef RAM_WRITE_CTRL_PINGPONG_EN
      bank_q      <= 1'b0;
      intr_bank_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      ram_en_q   <= ram_en_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_wr_q   <= ram_wr_d;
      intr_q     <= intr_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
`ifdef RAM_WRITE_CTRL_PINGPONG_EN
      bank_q      <= bank_d;
      intr_bank_q <= intr_bank_d;
`endif
    end
  end

  assign ram_clk   = clk;
  assign ram_rst_p = rst_p;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wr    = ram_wr_q;
  assign intr      = intr_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;
`ifdef RAM_WRITE_CTRL_PINGPONG_EN
  assign intr_bank = intr_bank_q;
`endif

endmodule

// File: tb/tb_ram_stream_writer.sv
// Scoreboard bench for ram_stream_writer: expected writes are queued at accept time and popped per RAM write.
module tb_ram_stream_writer;
  localparam int          DATA_W = 32;
  localparam int          ADDR_W = 32;
  localparam int          DEPTH  = 9;
  localparam int          STEP   = 4;
  localparam logic [31:0] BASE   = 32'h0;

  logic        clk = 1'b0;
  logic        rst_p = 1'b1;
  logic        en = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        intr_clr = 1'b0;
  logic        intr, ovf, busy, ram_clk, ram_rst_p, ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr, ram_wr;
  logic        intr_bank;

  logic        en2 = 1'b0;
  logic        s_valid2 = 1'b0;
  logic [31:0] s_data2 = '0;
  logic        s_ready2, intr2, ovf2, busy2, ram_clk2, ram_rst2, ram_en2, intr_bank2;
  logic [3:0]  ram_we2;
  logic [31:0] ram_addr2, ram_wr2;

  always #5 clk = ~clk;

  ram_stream_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE), .ADDR_STEP(STEP)) dut (
    .clk(clk), .rst_p(rst_p), .en(en), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .intr_clr(intr_clr), .intr(intr), .ovf(ovf),
`ifdef RAM_WRITE_CTRL_PINGPONG_EN
    .intr_bank(intr_bank),
`endif
    .busy(busy), .ram_clk(ram_clk), .ram_rst_p(ram_rst_p), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wr(ram_wr));

  ram_stream_writer #(.DATA_W(32), .ADDR_W(32), .DEPTH(3), .BASE_ADDR(32'hFFFF_FFF8), .ADDR_STEP(4)) dut_wrap (
    .clk(clk), .rst_p(rst_p), .en(en2), .s_data(s_data2), .s_valid(s_valid2), .s_ready(s_ready2),
    .intr_clr(1'b0), .intr(intr2), .ovf(ovf2),
`ifdef RAM_WRITE_CTRL_PINGPONG_EN
    .intr_bank(intr_bank2),
`endif
    .busy(busy2), .ram_clk(ram_clk2), .ram_rst_p(ram_rst2), .ram_en(ram_en2), .ram_we(ram_we2),
    .ram_addr(ram_addr2), .ram_wr(ram_wr2));

`ifndef RAM_WRITE_CTRL_PINGPONG_EN
  assign intr_bank  = 1'b0;
  assign intr_bank2 = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_k = 0;
  bit   exp_bank = 1'b0;
  bit   exp_last_bank = 1'b0;
  int   accepts = 0;
  int   writes = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] d);
    wr_t w;
    w.addr = BASE + 32'(exp_k * STEP) + (exp_bank ? 32'(DEPTH * STEP) : 32'd0);
    w.data = d;
    exp_q.push_back(w);
    accepts++;
    exp_k++;
    if (exp_k == DEPTH) begin
      exp_k = 0;
      exp_last_bank = exp_bank;
`ifdef RAM_WRITE_CTRL_PINGPONG_EN
      exp_bank = ~exp_bank;
`endif
    end
  endtask

  task automatic send_beat(input logic [31:0] d);
    int waited = 0;
    s_data  = d;
    s_valid = 1'b1;
    while (!s_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!s_ready) begin
      check_val("accept_timeout", 64'd0, 64'd1);
      s_valid = 1'b0;
      return;
    end
    push_exp(d);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] d0, input int max_gap, input bit clr_last, input int drop_en_at);
    for (int i = 0; i < DEPTH; i++) begin
      if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) tick();
      if (i == drop_en_at) en = 1'b0;
      intr_clr = clr_last && (i == DEPTH - 1);
      send_beat(d0 + 32'(i));
      intr_clr = 1'b0;
    end
  endtask

  task automatic check_bank();
`ifdef RAM_WRITE_CTRL_PINGPONG_EN
    check_val("intr_bank", intr_bank, exp_last_bank);
`endif
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_s_ready"}, s_ready, 0);
    check_val({tag, "_ram_en"}, ram_en, 0);
    check_val({tag, "_ram_we"}, ram_we, 0);
    check_val({tag, "_ram_addr"}, ram_addr, BASE);
    check_val({tag, "_ram_wr"}, ram_wr, 0);
    check_val({tag, "_intr"}, intr, 0);
    check_val({tag, "_ovf"}, ovf, 0);
    check_val({tag, "_busy"}, busy, 0);
`ifdef RAM_WRITE_CTRL_PINGPONG_EN
    check_val({tag, "_intr_bank"}, intr_bank, 0);
`endif
  endtask

  wr_t mon_e;
  always @(negedge clk) begin
    if (ram_en) begin
      writes++;
      if (exp_q.size() == 0) begin
        check_val("spurious_write", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        $display("write addr=0x%08h data=0x%08h (exp addr=0x%08h data=0x%08h)",
                 ram_addr, ram_wr, mon_e.addr, mon_e.data);
        check_val("ram_addr", ram_addr, mon_e.addr);
        check_val("ram_wr", ram_wr, mon_e.data);
        check_val("ram_we", ram_we, 4'hF);
      end
    end else begin
      check_val("ram_we_idle", ram_we, 0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wrap_exp [3];
    int n;
    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;

    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    check_val("ram_rst_p_hi", ram_rst_p, 1);
    check_val("ram_clk", ram_clk, clk);
    rst_p = 1'b0;
    #1;
    check_val("ram_rst_p_lo", ram_rst_p, 0);

    // Frame 1: back-to-back beats.
    en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      send_beat(32'hA0 + 32'(i));
      if (i == DEPTH - 2) check_val("f1_intr_early", intr, 0);
    end
    check_val("f1_intr", intr, 1);
    check_val("f1_ram_en_last", ram_en, 1);
    check_val("f1_ram_wr_last", ram_wr, 32'hA8);
    check_val("f1_ram_addr_last", ram_addr, BASE + 32'h20);
    check_val("f1_s_ready_done", s_ready, 0);
    check_val("f1_busy_done", busy, 1);
    check_val("f1_ovf", ovf, 0);
    check_bank();
    tick();
    check_val("f1_s_ready_rerun", s_ready, 1);

    // Frame 2 with random gaps, no intr_clr: overflow.
    send_frame(32'hB0, 3, 1'b0, -1);
    check_val("f2_intr", intr, 1);
    check_val("f2_ovf", ovf, 1);
    check_bank();

    // Frame 3 completes together with intr_clr.
    send_frame(32'hC0, 2, 1'b1, -1);
    check_val("f3_intr", intr, 1);
    check_val("f3_ovf", ovf, 1);
    check_bank();
    intr_clr = 1'b1;
    tick();
    intr_clr = 1'b0;
    check_val("clr_intr", intr, 0);
    check_val("clr_ovf", ovf, 0);

    // Frame 4: en dropped after beat 4.
    send_frame(32'hD0, 1, 1'b0, 4);
    check_val("f4_intr", intr, 1);
    check_val("f4_ovf", ovf, 0);
    check_val("f4_s_ready_done", s_ready, 0);
    check_val("f4_busy_done", busy, 1);
    check_bank();
    tick();
    check_val("f4_s_ready_idle", s_ready, 0);
    check_val("f4_busy_idle", busy, 0);
    tick();
    check_val("f4_s_ready_idle2", s_ready, 0);

    // Reset after beat 5 of a frame discards it.
    en = 1'b1;
    for (int i = 0; i < 5; i++) send_beat(32'hE0 + 32'(i));
    rst_p = 1'b1;
    tick();
    check_reset_state("midreset");
    rst_p = 1'b0;
    exp_k = 0;
    exp_bank = 1'b0;
    exp_last_bank = 1'b0;

    // Fresh frames after reset: start at the base again; banks alternate when enabled.
    send_frame(32'hF0, 0, 1'b0, -1);
    check_val("f5_intr", intr, 1);
    check_bank();
    send_frame(32'h100, 2, 1'b0, -1);
    check_bank();
    send_frame(32'h110, 1, 1'b0, -1);
    check_bank();
    en = 1'b0;
    repeat (3) tick();

    // Address wrap past all-ones on the second instance.
    en2 = 1'b1;
    s_valid2 = 1'b1;
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      s_data2 = 32'h55 + 32'(i);
      tick();
      if (ram_en2) begin
        $display("wrap write addr=0x%08h (exp 0x%08h)", ram_addr2, wrap_exp[n]);
        check_val("wrap_addr", ram_addr2, wrap_exp[n]);
        check_val("wrap_we", ram_we2, 4'hF);
        n++;
      end
    end
    check_val("wrap_count", n, 3);
    s_valid2 = 1'b0;
    en2 = 1'b0;
    repeat (2) tick();

    check_val("queue_empty", exp_q.size(), 0);
    check_val("write_count", writes, accepts);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
